// File: rtl/scpad_types_pkg.sv
// Shared scratchpad types: geometry, tile request struct and sequencer states.
package scpad_types_pkg;
   localparam int NUM_COLS      = 8;
   localparam int MAX_DIM_WIDTH = $clog2(NUM_COLS);
   localparam int ROW_IDX_WIDTH = 8;
   localparam int DIM_CNT_WIDTH = MAX_DIM_WIDTH + 1;
   // Widest tag any sequencer instance may carry; narrower tags are zero-extended.
   localparam int MAX_ID_WIDTH  = 16;

   typedef enum logic {IDLE, ISSUE} seq_state_t;

   typedef struct packed {
      logic                     row_or_col;
      logic [ROW_IDX_WIDTH-1:0] spad_addr;
      logic [DIM_CNT_WIDTH-1:0] num_rows;
      logic [DIM_CNT_WIDTH-1:0] num_cols;
      logic [MAX_ID_WIDTH-1:0]  id;
   } tile_req_t;

   function automatic logic [DIM_CNT_WIDTH-1:0] clamp_dim(input logic [DIM_CNT_WIDTH-1:0] n);
      return (n > DIM_CNT_WIDTH'(NUM_COLS)) ? DIM_CNT_WIDTH'(NUM_COLS) : n;
   endfunction
endpackage

// File: rtl/scpad_sat_counter.sv
// 32-bit saturating event counter; only built when SCPAD_SEQ_PERF_EN is defined.
`ifdef SCPAD_SEQ_PERF_EN
module scpad_sat_counter (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        inc,
   output logic [31:0] count
);
   always_ff @(posedge CLK) begin
      if (!nRST)                 count <= '0;
      else if (inc && count != '1) count <= count + 32'd1;
   end
endmodule
`endif

// File: rtl/scpad_tile_sequencer.sv
// Expands one tile request into per-row/per-column beats for the address mapper.
// Optional perf counters under SCPAD_SEQ_PERF_EN.
module scpad_tile_sequencer
   import scpad_types_pkg::*;
#(
   parameter int ID_WIDTH = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_row_or_col,
   input  logic [ROW_IDX_WIDTH-1:0] req_spad_addr,
   input  logic [DIM_CNT_WIDTH-1:0] req_num_rows,
   input  logic [DIM_CNT_WIDTH-1:0] req_num_cols,
   input  logic [ID_WIDTH-1:0]      req_id,
   output logic                     beat_valid,
   input  logic                     beat_ready,
   output logic                     beat_row_or_col,
   output logic [ROW_IDX_WIDTH-1:0] beat_spad_addr,
   output logic [DIM_CNT_WIDTH-1:0] beat_num_rows,
   output logic [DIM_CNT_WIDTH-1:0] beat_num_cols,
   output logic [MAX_DIM_WIDTH-1:0] beat_row_id,
   output logic [MAX_DIM_WIDTH-1:0] beat_col_id,
   output logic                     beat_last,
   output logic [ID_WIDTH-1:0]      beat_id,
   output logic                     done_valid,
   output logic [ID_WIDTH-1:0]      done_id,
   output logic                     busy
`ifdef SCPAD_SEQ_PERF_EN
   ,
   output logic [31:0]              perf_beats,
   output logic [31:0]              perf_stall_cycles
`endif
);
   seq_state_t               state;
   tile_req_t                req_q;
   logic [DIM_CNT_WIDTH-1:0] cnt, total, req_total;
   logic                     pend_valid;
   logic [ID_WIDTH-1:0]      pend_id;
   logic                     beat_fire, last_fire, req_fire;

   assign req_total = clamp_dim(req_row_or_col ? req_num_rows : req_num_cols);

   assign beat_valid = nRST && !flush && (state == ISSUE);
   assign beat_last  = (state == ISSUE) && (cnt == total - DIM_CNT_WIDTH'(1));
   assign beat_fire  = beat_valid && beat_ready;
   assign last_fire  = beat_fire && beat_last;
   // A zero-size request landing on a last beat parks its done one cycle; hold off
   // new requests until that pulse has gone out.
   assign req_ready  = nRST && !flush && !pend_valid && ((state == IDLE) || last_fire);
   assign req_fire   = req_valid && req_ready;

   assign beat_row_or_col = req_q.row_or_col;
   assign beat_spad_addr  = req_q.spad_addr;
   assign beat_num_rows   = req_q.num_rows;
   assign beat_num_cols   = req_q.num_cols;
   assign beat_id         = ID_WIDTH'(req_q.id);
   assign beat_row_id     = req_q.row_or_col  ? cnt[MAX_DIM_WIDTH-1:0] : '0;
   assign beat_col_id     = !req_q.row_or_col ? cnt[MAX_DIM_WIDTH-1:0] : '0;
   assign busy            = (state != IDLE);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= IDLE;
         req_q      <= '0;
         cnt        <= '0;
         total      <= '0;
         pend_valid <= 1'b0;
         pend_id    <= '0;
         done_valid <= 1'b0;
         done_id    <= '0;
      end else begin
         done_valid <= 1'b0;
         if (flush) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
         end else begin
            if (pend_valid) begin
               done_valid <= 1'b1;
               done_id    <= pend_id;
               pend_valid <= 1'b0;
            end
            if (beat_fire) begin
               cnt <= cnt + DIM_CNT_WIDTH'(1);
               if (beat_last) begin
                  done_valid <= 1'b1;
                  done_id    <= ID_WIDTH'(req_q.id);
                  state      <= IDLE;
               end
            end
            if (req_fire) begin
               req_q <= '{row_or_col: req_row_or_col, spad_addr: req_spad_addr,
                          num_rows: req_num_rows, num_cols: req_num_cols,
                          id: MAX_ID_WIDTH'(req_id)};
               cnt   <= '0;
               total <= req_total;
               if (req_total == '0) begin
                  state <= IDLE;
                  if (last_fire) begin
                     pend_valid <= 1'b1;
                     pend_id    <= req_id;
                  end else begin
                     done_valid <= 1'b1;
                     done_id    <= req_id;
                  end
               end else begin
                  state <= ISSUE;
               end
            end
         end
      end
   end

`ifdef SCPAD_SEQ_PERF_EN
   scpad_sat_counter u_perf_beats (
      .CLK(CLK), .nRST(nRST), .inc(beat_fire), .count(perf_beats)
   );
   scpad_sat_counter u_perf_stall (
      .CLK(CLK), .nRST(nRST), .inc(beat_valid && !beat_ready), .count(perf_stall_cycles)
   );
`endif
endmodule

// File: doc/scpad_tile_sequencer.md
# scpad_tile_sequencer

Walks one scratchpad tile request into a stream of per-row or per-column beats, one beat per cycle under valid/ready backpressure. Sits directly upstream of the scratchpad address mapper. Each beat carries the mode, base address, tile dimensions and current row/column index that the mapper turns into its per-bank crossbar descriptor. Signals completion of each request with a tagged done pulse.

## Interface
- Parameters (from scpad_types_pkg unless noted):
  - NUM_COLS: banks per scratchpad.
  - MAX_DIM_WIDTH: log2(NUM_COLS).
  - ROW_IDX_WIDTH: scratchpad slot address width.
  - ID_WIDTH (module parameter, default 4): request tag width.
- Ports (clock and reset first):
  - CLK  in  1  clock.
  - nRST  in  1  reset; **synchronous, active-low**.
  - flush  in  1  drop the in-flight request; no done is issued for it.
  - req_valid  in  1  tile request offered.
  - req_ready  out  1  request accepted when req_valid && req_ready.
  - req_row_or_col  in  1  1 = row-major walk; 0 = column-major walk.
  - req_spad_addr  in  ROW_IDX_WIDTH  tile base slot.
  - req_num_rows  in  MAX_DIM_WIDTH+1  tile rows, 0..NUM_COLS.
  - req_num_cols  in  MAX_DIM_WIDTH+1  tile columns, 0..NUM_COLS.
  - req_id  in  ID_WIDTH  request tag.
  - beat_valid  out  1  beat offered to the mapper.
  - beat_ready  in  1  mapper accepts the beat.
  - beat_row_or_col, beat_spad_addr, beat_num_rows, beat_num_cols  out  as req_*  latched request fields.
  - beat_row_id  out  MAX_DIM_WIDTH  current row (row-major); 0 in column-major.
  - beat_col_id  out  MAX_DIM_WIDTH  current column (column-major); 0 in row-major.
  - beat_last  out  1  final beat of the request.
  - beat_id  out  ID_WIDTH  tag of the owning request.
  - done_valid  out  1  one-cycle completion pulse.
  - done_id  out  ID_WIDTH  tag of the completed request.
  - busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: req_ready = 1 unless flush is high.
  - ISSUE: beat_valid = 1.
- Request accept in IDLE:
  - Latch all request fields and clear the beat counter.
  - Beat total N = num_rows if row_or_col = 1, else num_cols.
  - N = 0: stay in IDLE, issue no beats, and pulse done on the next cycle.
  - N > 0: go to ISSUE.
- Each beat handshake (beat_valid && beat_ready): counter increments.
  - The counter drives beat_row_id in row-major mode and beat_col_id in column-major mode.
  - The other index is held at 0.
  - beat_last = (counter == N-1).
- Last-beat handshake:
  - done_valid pulses on the next cycle, with done_id = latched id.
  - req_ready is also high in that same cycle, so back-to-back accept is allowed.
  - If a new request is accepted then: load it and stay in ISSUE (or go to IDLE if its N = 0, with its done pulse following that request's own rule). Otherwise go to IDLE.
- Arithmetic:
  - The counter is MAX_DIM_WIDTH+1 bits, compared against N.
  - The index outputs take its low MAX_DIM_WIDTH bits. N = NUM_COLS therefore reaches index NUM_COLS-1 with no wrap.
  - Values of N > NUM_COLS are clamped to NUM_COLS.
- flush (any state):
  - Next state is IDLE; beat_valid and req_ready are 0 that cycle.
  - No done is issued for the flushed request.
  - flush wins over a simultaneous req_valid or last-beat handshake; the done of a last beat fired in the flush cycle is suppressed.
- Beat payload is stable while beat_valid && !beat_ready.

## Timing
- Request accepted at edge N: first beat_valid at cycle N+1.
- Steady state: one beat per cycle.
- Last beat handshake at edge M: done_valid during cycle M+1.
- Reset (nRST low at an edge):
  - State IDLE, counter 0.
  - Every output 0 except req_ready = 1 once nRST is high.
  - Latched fields are cleared.
- Reset mid-request abandons it with no done.

## Configuration
- SCPAD_SEQ_PERF_EN defined: adds outputs perf_beats (32) and perf_stall_cycles (32).
  - perf_beats counts beat handshakes.
  - perf_stall_cycles counts cycles with beat_valid && !beat_ready.
  - Both saturate at all-ones and clear on reset only.
- Undefined: these ports and counters are absent; remaining behaviour is identical.

## Structure
- Add to scpad_types_pkg:
  - seq_state_t enum {IDLE, ISSUE}.
  - DIM_CNT_WIDTH = MAX_DIM_WIDTH+1.
  - tile_req_t packed struct (row_or_col, spad_addr, num_rows, num_cols, id).
- No sub-module except under SCPAD_SEQ_PERF_EN: scpad_sat_counter (32-bit saturating increment), instantiated twice.

## Test plan
- Row-major 3x4 tile at spad_addr 8, id 5, beat_ready always 1:
  - Beats row_id 0,1,2 on three consecutive cycles, col_id 0, beat_last on row_id 2.
  - done_valid with done_id 5 one cycle after.
- Column-major num_cols = NUM_COLS: col_id runs 0..NUM_COLS-1, beat_last only at NUM_COLS-1, no wrap.
- beat_ready toggled 1,0,0,1 on a 2-row tile:
  - Payload held during stall; two beats total.
  - perf_stall_cycles = 2 (with SCPAD_SEQ_PERF_EN).
- Zero-size request (num_rows = 0, row-major), id 3: no beat_valid; done_valid with id 3 one cycle after accept.
- Back-to-back requests id 1 (2 rows) then id 2 (1 row) held valid: gapless beats 0,1,0; done pulses for 1 and 2.
- flush asserted on the last-beat handshake of id 7: no done for 7; IDLE next cycle. nRST low mid-request: all outputs 0, busy 0.
